// File: rtl/branch_pkg.sv
// Shared opcode and field-width definitions for the EX-stage branch unit.
package branch_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned TID_W = 2;
    localparam int unsigned PC_W  = 7;
    localparam int unsigned NUM_THREADS = 4;

    localparam logic [OP_W-1:0] BR_NONE = 3'd0;
    localparam logic [OP_W-1:0] BR_BEQ  = 3'd1;
    localparam logic [OP_W-1:0] BR_BNE  = 3'd2;
    localparam logic [OP_W-1:0] BR_J    = 3'd3;
    localparam logic [OP_W-1:0] BR_JR   = 3'd4;
    localparam logic [OP_W-1:0] BR_CALL = 3'd5;
    localparam logic [OP_W-1:0] BR_RET  = 3'd6;

endpackage

// File: rtl/ras_stack.sv
// Per-thread return-address stacks. Each thread owns a circular buffer of
// DEPTH entries; overflow overwrites the oldest entry, pop on empty is ignored.
module ras_stack
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [TID_W-1:0] tid,
    input  logic [PC_W-1:0]  push_data,
    output logic [PC_W-1:0]  top,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  mem [NUM_THREADS][DEPTH];
    logic [PTR_W-1:0] ptr [NUM_THREADS];
    logic [CNT_W-1:0] cnt [NUM_THREADS];
    logic [PTR_W-1:0] top_idx;

    // ptr marks the next free slot, so the top of stack sits one below it
    always_comb begin
        top_idx = ptr[tid] - 1'b1;
        top     = mem[tid][top_idx];
        empty   = (cnt[tid] == '0);
    end

    // Entry storage needs no reset: empty stacks never expose their contents
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tid][ptr[tid]] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping for the selected thread only
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned t = 0; t < NUM_THREADS; t++) begin
                ptr[t] <= '0;
                cnt[t] <= '0;
            end
        end else if (push) begin
            ptr[tid] <= ptr[tid] + 1'b1;
            if (cnt[tid] != CNT_W'(DEPTH)) begin
                cnt[tid] <= cnt[tid] + 1'b1;
            end
        end else if (pop && (cnt[tid] != '0)) begin
            ptr[tid] <= ptr[tid] - 1'b1;
            cnt[tid] <= cnt[tid] - 1'b1;
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution for the 4-thread barrel pipeline.
// Optional return-address stack for CALL/RET enabled by BRANCH_RAS_EN.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_reset_pulse,
    input  logic              advance,
    input  logic              id_valid,
    input  logic [1:0]        id_thread_id,
    input  logic [8:0]        id_pc,
    input  logic [2:0]        id_br_op,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [8:0]        id_offset,
    output logic              ex_branch_taken,
    output logic [8:0]        ex_branch_target,
    output logic [1:0]        ex_thread_id,
    output logic [15:0]       taken_count
);

    logic              clear;
    logic              ex_valid;
    logic [8:0]        ex_pc;
    logic [OP_W-1:0]   ex_op;
    logic [DATA_W-1:0] ex_rs;
    logic [DATA_W-1:0] ex_rt;
    logic [8:0]        ex_off;

    logic              cond;
    logic [PC_W-1:0]   seq_pc;
    logic [PC_W-1:0]   tgt7;
    logic              unused_hi_bits;

    assign clear          = reset | pc_reset_pulse;
    assign seq_pc         = ex_pc[PC_W-1:0] + 7'd1;
    // Thread bits of pc/offset are redundant with ex_thread_id in 7-bit arithmetic
    assign unused_hi_bits = ^{ex_pc[8:7], ex_off[8:7]};

    // EX pipeline registers: load on advance, clear overrides advance
    always_ff @(posedge clk) begin
        if (clear) begin
            ex_valid     <= 1'b0;
            ex_thread_id <= '0;
            ex_pc        <= '0;
            ex_op        <= BR_NONE;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_off       <= '0;
        end else if (advance) begin
            ex_valid     <= id_valid;
            ex_thread_id <= id_thread_id;
            ex_pc        <= id_pc;
            ex_op        <= id_br_op;
            ex_rs        <= id_rs_data;
            ex_rt        <= id_rt_data;
            ex_off       <= id_offset;
        end
    end

`ifdef BRANCH_RAS_EN
    logic            ras_push;
    logic            ras_pop;
    logic [PC_W-1:0] ras_top;
    logic            ras_empty;

    // Stack updates ride the same edge as the EX reload, never on a clear
    assign ras_push = advance & ~clear & ex_valid & (ex_op == BR_CALL);
    assign ras_pop  = advance & ~clear & ex_valid & (ex_op == BR_RET);

    ras_stack #(
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (clear),
        .push      (ras_push),
        .pop       (ras_pop),
        .tid       (ex_thread_id),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`endif

    // Branch condition and 7-bit wrapping target from EX state
    always_comb begin
        cond = 1'b0;
        tgt7 = '0;
        case (ex_op)
            BR_BEQ: begin
                cond = (ex_rs == ex_rt);
                tgt7 = seq_pc + ex_off[PC_W-1:0];
            end
            BR_BNE: begin
                cond = (ex_rs != ex_rt);
                tgt7 = seq_pc + ex_off[PC_W-1:0];
            end
            BR_J, BR_CALL: begin
                cond = 1'b1;
                tgt7 = ex_off[PC_W-1:0];
            end
            BR_JR: begin
                cond = 1'b1;
                tgt7 = ex_rs[PC_W-1:0];
            end
`ifdef BRANCH_RAS_EN
            BR_RET: begin
                cond = 1'b1;
                tgt7 = ras_empty ? '0 : ras_top;
            end
`endif
            default: begin
                cond = 1'b0;
                tgt7 = '0;
            end
        endcase
    end

    assign ex_branch_taken  = ex_valid & cond;
    assign ex_branch_target = {ex_thread_id, ex_branch_taken ? tgt7 : 7'd0};

    // Saturating count of taken branches consumed by the PC generator
    always_ff @(posedge clk) begin
        if (clear) begin
            taken_count <= '0;
        end else if (advance && ex_branch_taken && (taken_count != 16'hFFFF)) begin
            taken_count <= taken_count + 16'd1;
        end
    end

endmodule
